// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared key indices, player ids and event record layout for the key scheduler
package key_evt_pkg;

    localparam int KEY_W     = 0;
    localparam int KEY_A     = 1;
    localparam int KEY_S     = 2;
    localparam int KEY_D     = 3;
    localparam int KEY_F     = 4;
    localparam int KEY_ENTER = 5;
    localparam int KEY_I     = 6;
    localparam int KEY_J     = 7;
    localparam int KEY_K     = 8;
    localparam int KEY_L     = 9;
    localparam int KEY_R     = 10;
    localparam int KEY_T     = 11;

    localparam int KEY_IDX_W = 4;
    // Record layout, msb to lsb: {key, player, repeat}
    localparam int EVT_W     = KEY_IDX_W + 2;

    localparam logic PLAYER_0 = 1'b0;
    localparam logic PLAYER_1 = 1'b1;

    function automatic logic [EVT_W-1:0] evt_pack(input logic [KEY_IDX_W-1:0] key,
                                                  input logic player,
                                                  input logic rpt);
        return {key, player, rpt};
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - show-ahead synchronous event queue; a pop frees a slot for a same-cycle push
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_level    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// rtl/key_event_scheduler.sv - key press/repeat event generator with round-robin player arbitration
// Optional typematic auto-repeat: KEY_AUTOREPEAT_EN
module key_event_scheduler
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS      = 12,
    parameter int FIFO_DEPTH    = 4,
    parameter int TICK_DIV      = 100000,
    parameter int REPEAT_DELAY  = 400,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KEYS-1:0]           key_vec,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [3:0]                    evt_key,
    output logic                          evt_player,
    output logic                          evt_repeat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt
);
    localparam int HALF = NUM_KEYS / 2;

    logic                  r_armed;
    logic                  r_rr;
    logic [NUM_KEYS-1:0]   r_key_prev;
    logic [NUM_KEYS-1:0]   r_pending;
    logic [NUM_KEYS-1:0]   r_pend_rep;
    logic [7:0]            r_drop_cnt;

    logic [NUM_KEYS-1:0]   w_rise;
    logic [NUM_KEYS-1:0]   w_rep;
    logic [NUM_KEYS-1:0]   w_set;
    logic [NUM_KEYS-1:0]   w_grant;
    logic [NUM_KEYS-1:0]   w_coal;
    logic                  w_req0;
    logic                  w_req1;
    logic                  w_win_player;
    logic [3:0]            w_idx0;
    logic [3:0]            w_idx1;
    logic [3:0]            w_win_idx;
    logic                  w_grant_any;
    logic                  w_can_push;
    logic                  w_full;
    logic                  w_empty;
    logic [EVT_W-1:0]      w_push_data;
    logic [EVT_W-1:0]      w_head;
    logic [8:0]            w_drop_sum;

    assign w_rise = {NUM_KEYS{r_armed}} & key_vec & ~r_key_prev;

`ifdef KEY_AUTOREPEAT_EN
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int TW = $clog2(REPEAT_DELAY + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] T_RELOAD = TW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [PW-1:0]       r_presc;
    logic [TW-1:0]       r_timer [NUM_KEYS];
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_hit;

    assign w_tick = (r_presc == PRE_MAX);

    // The timer reloads on a hit even before arming so it can never run past REPEAT_DELAY
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            w_hit[i] = w_tick & key_vec[i] & ~w_rise[i] & (r_timer[i] == T_LAST);
    end
    assign w_rep = w_hit & {NUM_KEYS{r_armed}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            for (int i = 0; i < NUM_KEYS; i++) r_timer[i] <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (w_rise[i] || !key_vec[i]) r_timer[i] <= '0;
                else if (w_hit[i])            r_timer[i] <= T_RELOAD;
                else if (w_tick)              r_timer[i] <= r_timer[i] + 1'b1;
            end
        end
    end
`else
    logic w_cfg_unused;
    assign w_cfg_unused = (TICK_DIV + REPEAT_DELAY + REPEAT_PERIOD) != 0;
    assign w_rep        = '0;
`endif

    assign w_set      = w_rise | w_rep;
    assign w_can_push = ~w_full | evt_ready;

    always_comb begin
        w_idx0 = '0;
        for (int i = HALF - 1; i >= 0; i--)
            if (r_pending[i]) w_idx0 = 4'(i);
        w_idx1 = '0;
        for (int i = NUM_KEYS - 1; i >= HALF; i--)
            if (r_pending[i]) w_idx1 = 4'(i);
        w_req0       = |r_pending[HALF-1:0];
        w_req1       = |r_pending[NUM_KEYS-1:HALF];
        w_win_player = (w_req0 && w_req1) ? r_rr : (w_req1 ? PLAYER_1 : PLAYER_0);
        w_win_idx    = (w_win_player == PLAYER_1) ? w_idx1 : w_idx0;
        w_grant_any  = (w_req0 | w_req1) & w_can_push;
        w_grant      = '0;
        if (w_grant_any) w_grant[w_win_idx] = 1'b1;
    end

    assign w_push_data = evt_pack(w_win_idx, w_win_player, r_pend_rep[w_win_idx]);
    assign w_coal      = w_set & r_pending & ~w_grant;

    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int i = 0; i < NUM_KEYS; i++)
            if (w_coal[i]) w_drop_sum = w_drop_sum + 9'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed    <= 1'b0;
            r_rr       <= PLAYER_0;
            r_key_prev <= '0;
            r_pending  <= '0;
            r_pend_rep <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_armed    <= 1'b1;
            r_key_prev <= key_vec;
            // A set in the grant cycle wins, so the bit survives as a second event
            r_pending  <= w_set | (r_pending & ~w_grant);
            r_pend_rep <= (w_set & w_rep & ~w_rise) | (r_pend_rep & ~w_set & ~w_grant);
            if (w_grant_any && w_req0 && w_req1) r_rr <= ~w_win_player;
            r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_grant_any),
        .i_push_data (w_push_data),
        .i_pop       (evt_ready),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    assign evt_valid  = ~w_empty;
    assign evt_key    = w_head[EVT_W-1:2];
    assign evt_player = w_head[1];
    assign evt_repeat = w_head[0];
    assign drop_cnt   = r_drop_cnt;

endmodule
